seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/bcd_to_seven_seg.sv | 17 +
 rtl/seven_seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
// Segment patterns are active-low, bit order a..g = [6:0].
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b111_1111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b000_0001,  // 0
        7'b100_1111,  // 1
        7'b001_0010,  // 2
        7'b000_0110,  // 3
        7'b100_1100,  // 4
        7'b010_0100,  // 5
        7'b010_0000,  // 6
        7'b000_1111,  // 7
        7'b000_0000,  // 8
        7'b000_0100   // 9
    };

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes 10..15 decode to a dark digit.
module bcd_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment controller with blanking gaps
// between digits and frame-aligned data updates so the display never tears.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  digit_en,
    output logic [6:0]  segments,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        busy
);

    localparam int MAX_CYCLES = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_e   state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          started_q, started_d;
    logic [15:0]   pendData_q, pendData_d;
    logic [3:0]    pendEn_q, pendEn_d;
    logic [15:0]   actData_q, actData_d;
    logic [3:0]    actEn_q, actEn_d;
    logic          busy_q, busy_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frameDone_q, frameDone_d;

    logic          blankEnd;
    logic          frameSwap;
    logic [3:0]    curDigit;
    logic [6:0]    curPattern;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            pendData_q  <= 16'h0000;
            pendEn_q    <= 4'b0000;
            actData_q   <= 16'h0000;
            actEn_q     <= 4'b0000;
            busy_q      <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            started_q   <= started_d;
            pendData_q  <= pendData_d;
            pendEn_q    <= pendEn_d;
            actData_q   <= actData_d;
            actEn_q     <= actEn_d;
            busy_q      <= busy_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Slot sequencing; the end of the initial blank is also a swap point so
    // a value loaded right after reset shows up in the very first digit-0 slot.
    always_comb begin
        blankEnd  = (state_q == BLANK) && (cnt_q == BLANK_LAST);
        frameSwap = blankEnd && (idx_q == 2'd0);

        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CW'(1);
        started_d = started_q;

        case (state_q)
            BLANK: begin
                if (blankEnd) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                started_d = 1'b1;
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: ;
        endcase

        pendData_d = load ? data_in  : pendData_q;
        pendEn_d   = load ? digit_en : pendEn_q;
        actData_d  = actData_q;
        actEn_d    = actEn_q;
        busy_d     = busy_q;
        if (frameSwap) begin
            actData_d = load ? data_in  : pendData_q;
            actEn_d   = load ? digit_en : pendEn_q;
            busy_d    = 1'b0;
        end else if (load) begin
            busy_d = 1'b1;
        end
    end

    assign curDigit = actData_d[{idx_d, 2'b00} +: 4];

    bcd_to_seven_seg u_decoder (
        .digit_i (curDigit),
        .seg_o   (curPattern)
    );

    // Outputs are registered from the next-state values so pins line up with the state.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if ((state_d == SHOW) && actEn_d[idx_d]) begin
            seg_d = curPattern;
            an_d  = ~(4'b0001 << idx_d);
        end
        frameDone_d = (state_d == BLANK) && (idx_d == 2'd0) &&
                      (cnt_d == BLANK_LAST) && started_d;
    end

    assign segments   = seg_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl with a 24-cycle frame
// (4 cycles per digit, 2 blank cycles between digits).
module tb_seven_seg_scan_ctrl;

    localparam logic [6:0] SEG0 = 7'b000_0001;
    localparam logic [6:0] SEG1 = 7'b100_1111;
    localparam logic [6:0] SEG2 = 7'b001_0010;
    localparam logic [6:0] SEG3 = 7'b000_0110;
    localparam logic [6:0] SEG4 = 7'b100_1100;
    localparam logic [6:0] SEG5 = 7'b010_0100;
    localparam logic [6:0] SEG8 = 7'b000_0000;
    localparam logic [6:0] SEG9 = 7'b000_0100;
    localparam logic [6:0] SEGX = 7'b111_1111;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  digit_en;
    logic [6:0]  segments;
    logic [3:0]  an;
    logic        frame_done;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .digit_en   (digit_en),
        .segments   (segments),
        .an         (an),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] en);
        load     = ld;
        data_in  = d;
        digit_en = en;
    endtask

    // Walks frame offsets 1..24 (offset 24 is the boundary cycle) and checks the
    // scan pattern expected for the given enables and per-digit segment patterns.
    task automatic runSteps(input string tag, input int first, input int count,
                            input logic [3:0] en, input logic [27:0] segs);
        for (int o = first; o < first + count; o++) begin
            int         slot;
            int         pos;
            logic [3:0] expAn;
            logic [6:0] expSeg;
            @(negedge clk);
            slot   = (o - 1) / 6;
            pos    = (o - 1) % 6;
            expAn  = 4'hF;
            expSeg = SEGX;
            if (pos < 4 && en[slot]) begin
                expAn  = ~(4'b0001 << slot);
                expSeg = segs[7*slot +: 7];
            end
            checkOutput($sformatf("%s an @%0d", tag, o), {12'h0, an}, {12'h0, expAn});
            checkOutput($sformatf("%s seg @%0d", tag, o), {9'h0, segments}, {9'h0, expSeg});
            checkOutput($sformatf("%s frame_done @%0d", tag, o), {15'h0, frame_done},
                        {15'h0, (o == 24)});
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("reset an", {12'h0, an}, 16'h000F);
        checkOutput("reset seg", {9'h0, segments}, 16'h007F);
        checkOutput("reset busy", {15'h0, busy}, 16'h0000);
        checkOutput("reset frame_done", {15'h0, frame_done}, 16'h0000);

        // First bring-up, then reset again in the middle of digit 0 with a load pending.
        reset = 1'b0;
        applyStimulus(1'b1, 16'h4321, 4'b1111);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        runSteps("bringup", 1, 2, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        reset = 1'b1;
        applyStimulus(1'b1, 16'h8888, 4'b1111);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkOutput("midreset an", {12'h0, an}, 16'h000F);
        checkOutput("midreset seg", {9'h0, segments}, 16'h007F);
        checkOutput("midreset busy", {15'h0, busy}, 16'h0000);
        repeat (2) @(negedge clk);

        reset = 1'b0;
        applyStimulus(1'b1, 16'h4321, 4'b1111);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkOutput("post-reset busy", {15'h0, busy}, 16'h0001);
        checkOutput("post-reset an", {12'h0, an}, 16'h000F);
        checkOutput("initial blank frame_done", {15'h0, frame_done}, 16'h0000);
        runSteps("scan f1", 1, 1, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        checkOutput("scan f1 busy", {15'h0, busy}, 16'h0000);
        runSteps("scan f1", 2, 23, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        runSteps("scan f2", 1, 24, 4'b1111, {SEG4, SEG3, SEG2, SEG1});

        // Mid-frame load waits for the frame boundary.
        runSteps("aligned old", 1, 8, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        applyStimulus(1'b1, 16'h8888, 4'b1111);
        runSteps("aligned old", 9, 1, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkOutput("aligned busy set", {15'h0, busy}, 16'h0001);
        runSteps("aligned old", 10, 15, 4'b1111, {SEG4, SEG3, SEG2, SEG1});
        checkOutput("aligned busy at boundary", {15'h0, busy}, 16'h0001);
        runSteps("aligned new", 1, 1, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        checkOutput("aligned busy cleared", {15'h0, busy}, 16'h0000);
        runSteps("aligned new", 2, 23, 4'b1111, {SEG8, SEG8, SEG8, SEG8});

        // Two loads in one frame: only the last one is ever displayed.
        runSteps("overwrite old", 1, 3, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        applyStimulus(1'b1, 16'h1111, 4'b1111);
        runSteps("overwrite old", 4, 1, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        runSteps("overwrite old", 5, 6, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        applyStimulus(1'b1, 16'h2222, 4'b1111);
        runSteps("overwrite old", 11, 1, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        runSteps("overwrite old", 12, 13, 4'b1111, {SEG8, SEG8, SEG8, SEG8});
        checkOutput("overwrite busy", {15'h0, busy}, 16'h0001);
        runSteps("overwrite new", 1, 24, 4'b1111, {SEG2, SEG2, SEG2, SEG2});

        // Load on the frame_done cycle goes straight to the display.
        applyStimulus(1'b1, 16'h0000, 4'b1111);
        runSteps("boundary load", 1, 1, 4'b1111, {SEG0, SEG0, SEG0, SEG0});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkOutput("boundary busy @1", {15'h0, busy}, 16'h0000);
        runSteps("boundary load", 2, 1, 4'b1111, {SEG0, SEG0, SEG0, SEG0});
        checkOutput("boundary busy @2", {15'h0, busy}, 16'h0000);
        runSteps("boundary load", 3, 22, 4'b1111, {SEG0, SEG0, SEG0, SEG0});

        // Disabled digits stay dark for their whole slot.
        applyStimulus(1'b1, 16'hF905, 4'b0101);
        runSteps("enables", 1, 1, 4'b0101, {SEGX, SEG9, SEG0, SEG5});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        runSteps("enables", 2, 23, 4'b0101, {SEGX, SEG9, SEG0, SEG5});

        // Code F on an enabled digit: anode active but segments dark.
        applyStimulus(1'b1, 16'hF905, 4'b1111);
        runSteps("code F", 1, 1, 4'b1111, {SEGX, SEG9, SEG0, SEG5});
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        runSteps("code F", 2, 23, 4'b1111, {SEGX, SEG9, SEG0, SEG5});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
